// File: rtl/data_bus_if.sv
// data_bus_if: core-to-memory bus between the core (master) and data_bus (slave).
//   address  : byte address driven by the core
//   data_out : write data driven by the core
//   we       : write enable driven by the core
//   data_in  : registered read data returned to the core
interface data_bus_if;
  logic [31:0] address;
  logic [31:0] data_out;
  logic        we;
  logic [31:0] data_in;

  modport master (
    output address,
    output data_out,
    output we,
    input  data_in
  );

  modport slave (
    input  address,
    input  data_out,
    input  we,
    output data_in
  );
endinterface

// File: rtl/data_bus.sv
// data_bus: unified instruction/data RAM plus a 16-byte MMIO register window.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high reset
//   bus       : data_bus_if slave modport (address, data_out, we in; data_in out)
//   leds      : LED register
//   halt      : sticky halt flag set by a TOHOST write
//   halt_code : value written to TOHOST
//   bus_fault : sticky fault flag (cleared by writing 1 to STATUS)
// Register window at MMIO_BASE: +0x0 LED, +0x4 CYCLE, +0x8 TOHOST, +0xC STATUS.
// Build option: define CYCLE_COUNTER_EN to build the free-running CYCLE counter;
// otherwise CYCLE reads as 0 and remains a legal address.
module data_bus #(
  parameter int unsigned MEM_WORDS  = 4096,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter logic [31:0] FAULT_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  data_bus_if.slave   bus,
  output logic [7:0]  leds,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        bus_fault
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   data_in_q, data_in_d;
  logic [7:0]    leds_q;
  logic          halt_q;
  logic [31:0]   halt_code_q;
  logic          fault_q;
  logic [31:0]   cycle_val;

  logic          in_ram, in_mmio, fault;
  logic          wr_ok;
  logic [AW-1:0] idx;
  logic [1:0]    reg_sel;

  assign idx     = bus.address[AW+1:2];
  assign reg_sel = bus.address[3:2];

  // MEM_WORDS is a power of two, so "below the RAM size" means all bits above
  // the word index are zero.
  assign in_ram  = (bus.address[31:AW+2] == '0);
  assign in_mmio = (bus.address[31:4] == MMIO_BASE[31:4]);
  assign fault   = (bus.address[1:0] != 2'b00) || !(in_ram || in_mmio);

  // Single qualifier for every state-changing write.
  assign wr_ok   = bus.we && !halt_q && !reset && !fault;

  // RAM: no reset, read-first via the registered read path below.
  always_ff @(posedge clk) begin
    if (wr_ok && in_ram) begin
      mem[idx] <= bus.data_out;
    end
  end

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  // Freezes once halt is set; the edge that sets halt still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else if (!halt_q) begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  // Read mux; all values are pre-edge so MMIO read-during-write is read-first.
  always_comb begin
    data_in_d = '0;
    if (fault) begin
      data_in_d = FAULT_DATA;
    end else if (in_ram) begin
      data_in_d = mem[idx];
    end else begin
      unique case (reg_sel)
        2'd0: data_in_d = {24'b0, leds_q};
        2'd1: data_in_d = cycle_val;
        2'd2: data_in_d = {31'b0, halt_q};
        2'd3: data_in_d = {31'b0, fault_q};
        default: data_in_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_in_q   <= '0;
      leds_q      <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      data_in_q <= data_in_d;
      if (wr_ok && in_mmio) begin
        unique case (reg_sel)
          2'd0: leds_q <= bus.data_out[7:0];
          2'd2: begin
            halt_q      <= 1'b1;
            halt_code_q <= bus.data_out;
          end
          default: ;
        endcase
      end
      // A STATUS clear is itself non-faulting, so set and clear never collide.
      if (fault) begin
        fault_q <= 1'b1;
      end else if (wr_ok && in_mmio && reg_sel == 2'd3 && bus.data_out[0]) begin
        fault_q <= 1'b0;
      end
    end
  end

  assign bus.data_in = data_in_q;
  assign leds        = leds_q;
  assign halt        = halt_q;
  assign halt_code   = halt_code_q;
  assign bus_fault   = fault_q;

endmodule
